// File: rtl/mem_ctrl_pkg.sv
// Shared constants and helpers for the byte-serial main-memory controller.
package mem_ctrl_pkg;
    localparam int ADDR_LEN = 32;
    localparam int INS_LEN  = 32;

    localparam logic [2:0] W_BYTE = 3'd1;
    localparam logic [2:0] W_HALF = 3'd2;
    localparam logic [2:0] W_WORD = 3'd4;

    localparam logic [1:0] IO_MASK = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_IFETCH, S_LOAD, S_STORE, S_DONE
    } state_e;

    // Any width code other than a byte or half-word is a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] w);
        case (w)
            W_BYTE:  return W_BYTE;
            W_HALF:  return W_HALF;
            default: return W_WORD;
        endcase
    endfunction

    function automatic logic is_io(input logic [ADDR_LEN-1:0] a, input logic [1:0] mask);
        return a[17:16] == mask;
    endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// Client request/response pairs plus the byte-wide RAM port of mem_ctrl.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                icache_in_flag;
    logic [ADDR_LEN-1:0] icache_addr;
    logic                icache_out_flag;
    logic [INS_LEN-1:0]  icache_ins;
    logic                lsb_in_flag;
    logic                lsb_wr;
    logic [2:0]          lsb_width;
    logic [ADDR_LEN-1:0] lsb_addr;
    logic [INS_LEN-1:0]  lsb_wdata;
    logic                lsb_out_flag;
    logic [INS_LEN-1:0]  lsb_rdata;
    logic [7:0]          mem_din;
    logic [7:0]          mem_dout;
    logic [ADDR_LEN-1:0] mem_a;
    logic                mem_wr;
    logic                io_buffer_full;

    modport slave (
        input  icache_in_flag, icache_addr, lsb_in_flag, lsb_wr, lsb_width,
               lsb_addr, lsb_wdata, mem_din, io_buffer_full,
        output icache_out_flag, icache_ins, lsb_out_flag, lsb_rdata,
               mem_dout, mem_a, mem_wr
    );

    modport master (
        output icache_in_flag, icache_addr, lsb_in_flag, lsb_wr, lsb_width,
               lsb_addr, lsb_wdata, mem_din, io_buffer_full,
        input  icache_out_flag, icache_ins, lsb_out_flag, lsb_rdata,
               mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_byte_seq.sv
// Byte sequencer: access base/length/data, byte counter and little-endian assembly.
module mem_byte_seq import mem_ctrl_pkg::*; #(
    parameter int ADDR_W = ADDR_LEN,
    parameter int DATA_W = INS_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ready,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        len_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              adv_i,
    input  logic              cap_i,
    input  logic [7:0]        din_i,
    output logic [2:0]        cnt_o,
    output logic [2:0]        len_o,
    output logic [ADDR_W-1:0] base_o,
    output logic [ADDR_W-1:0] nxt_addr_o,
    output logic [7:0]        nxt_byte_o,
    output logic [DATA_W-1:0] word_o
);
    logic [2:0]        cnt_q, len_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q, buf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            len_q   <= W_WORD;
            base_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
        end else if (ready) begin
            if (start_i) begin
                cnt_q   <= '0;
                len_q   <= len_i;
                base_q  <= addr_i;
                wdata_q <= wdata_i;
                buf_q   <= '0;
            end else begin
                if (adv_i) cnt_q <= cnt_q + 3'd1;
                // RAM output lags the address by one cycle, so din holds byte cnt-1.
                if (cap_i) buf_q[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] <= din_i;
            end
        end
    end

    // Last byte comes straight from the RAM so the result is ready on the finish edge.
    always_comb begin
        word_o = buf_q;
        for (int i = 0; i < DATA_W / 8; i++)
            if (3'(i) == len_q - 3'd1) word_o[8*i +: 8] = din_i;
    end

    assign cnt_o      = cnt_q;
    assign len_o      = len_q;
    assign base_o     = base_q;
    assign nxt_addr_o = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
    assign nxt_byte_o = wdata_q[{cnt_q[1:0] + 2'd1, 3'b000} +: 8];
endmodule

// File: rtl/mem_ctrl.sv
// Main-memory port owner: arbitrates icache fetches and lsb loads/stores onto byte RAM cycles.
module mem_ctrl import mem_ctrl_pkg::*; #(
    parameter int         ADDR_W     = ADDR_LEN,
    parameter int         DATA_W     = INS_LEN,
    parameter logic [1:0] IO_MASK_HI = IO_MASK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    input  logic       clear,
    mem_ctrl_if.slave  bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              ic_flag_q, ic_flag_d, lsb_flag_q, lsb_flag_d;
    logic [DATA_W-1:0] ic_ins_q, ic_ins_d, lsb_rdata_q, lsb_rdata_d;

    logic              seq_start, seq_adv, seq_cap;
    logic [ADDR_W-1:0] seq_addr, seq_base, seq_nxt_addr;
    logic [2:0]        seq_len, seq_cnt, seq_len_q;
    logic [DATA_W-1:0] seq_wdata, seq_word;
    logic [7:0]        seq_nxt_byte;
    logic              lsb_go, store_io_stall;

    mem_byte_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_seq (
        .clk(clk), .reset(reset), .ready(ready),
        .start_i(seq_start), .addr_i(seq_addr), .len_i(seq_len), .wdata_i(seq_wdata),
        .adv_i(seq_adv), .cap_i(seq_cap), .din_i(bus.mem_din),
        .cnt_o(seq_cnt), .len_o(seq_len_q), .base_o(seq_base),
        .nxt_addr_o(seq_nxt_addr), .nxt_byte_o(seq_nxt_byte), .word_o(seq_word)
    );

    assign lsb_go = bus.lsb_in_flag &&
                    !(bus.lsb_wr && is_io(bus.lsb_addr, IO_MASK_HI) && bus.io_buffer_full);
    assign store_io_stall = is_io(seq_base, IO_MASK_HI) && bus.io_buffer_full;

    always_comb begin
        state_d     = state_q;
        mem_a_d     = mem_a_q;
        mem_dout_d  = mem_dout_q;
        mem_wr_d    = 1'b0;
        ic_flag_d   = 1'b0;
        lsb_flag_d  = 1'b0;
        ic_ins_d    = ic_ins_q;
        lsb_rdata_d = lsb_rdata_q;
        seq_start   = 1'b0;
        seq_adv     = 1'b0;
        seq_cap     = 1'b0;
        seq_addr    = bus.lsb_addr;
        seq_len     = norm_len(bus.lsb_width);
        seq_wdata   = bus.lsb_wdata;
        case (state_q)
            S_IDLE: if (!clear) begin
                if (lsb_go) begin
                    seq_start = 1'b1;
                    mem_a_d   = bus.lsb_addr;
                    if (bus.lsb_wr) begin
                        mem_dout_d = bus.lsb_wdata[7:0];
                        mem_wr_d   = 1'b1;
                        state_d    = S_STORE;
                    end else begin
                        state_d    = S_LOAD;
                    end
                end else if (bus.icache_in_flag) begin
                    seq_start = 1'b1;
                    seq_addr  = bus.icache_addr;
                    seq_len   = W_WORD;
                    mem_a_d   = bus.icache_addr;
                    state_d   = S_IFETCH;
                end
            end
            S_IFETCH, S_LOAD: begin
                if (clear) begin
                    state_d = S_IDLE;
                end else if (seq_cnt == seq_len_q) begin
                    state_d = S_DONE;
                    if (state_q == S_IFETCH) begin
                        ic_flag_d = 1'b1;
                        ic_ins_d  = seq_word;
                    end else begin
                        lsb_flag_d  = 1'b1;
                        lsb_rdata_d = seq_word;
                    end
                end else begin
                    seq_adv = 1'b1;
                    seq_cap = (seq_cnt != 3'd0);
                    if (seq_cnt + 3'd1 < seq_len_q) mem_a_d = seq_nxt_addr;
                end
            end
            // A write cycle seen with the IO buffer full is not taken; it is re-issued once it drains.
            S_STORE: if (!store_io_stall) begin
                if (!mem_wr_q) begin
                    mem_wr_d = 1'b1;
                end else if (seq_cnt + 3'd1 < seq_len_q) begin
                    seq_adv    = 1'b1;
                    mem_a_d    = seq_nxt_addr;
                    mem_dout_d = seq_nxt_byte;
                    mem_wr_d   = 1'b1;
                end else begin
                    lsb_flag_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mem_a_q     <= '0;
            mem_dout_q  <= '0;
            mem_wr_q    <= 1'b0;
            ic_flag_q   <= 1'b0;
            lsb_flag_q  <= 1'b0;
            ic_ins_q    <= '0;
            lsb_rdata_q <= '0;
        end else if (ready) begin
            state_q     <= state_d;
            mem_a_q     <= mem_a_d;
            mem_dout_q  <= mem_dout_d;
            mem_wr_q    <= mem_wr_d;
            ic_flag_q   <= ic_flag_d;
            lsb_flag_q  <= lsb_flag_d;
            ic_ins_q    <= ic_ins_d;
            lsb_rdata_q <= lsb_rdata_d;
        end
    end

    assign bus.mem_a           = mem_a_q;
    assign bus.mem_dout        = mem_dout_q;
    assign bus.mem_wr          = mem_wr_q;
    assign bus.icache_out_flag = ic_flag_q;
    assign bus.icache_ins      = ic_ins_q;
    assign bus.lsb_out_flag    = lsb_flag_q;
    assign bus.lsb_rdata       = lsb_rdata_q;
endmodule
